video_timing_ctrl: RTL and testbench

Sequencer for the video pixel pipeline: generates `h_cnt`/`v_cnt` raster counters and `dv`/`hs`/`vs` timing strobes for the image-processing datapath and its regression bench. Start/stop command handshake: frames begin only on command and always end on a frame boundary, so downstream line buffers never see a truncated frame. Sits at the head of the pipeline and replaces free-running timing.

---
 rtl/video_timing_pkg.sv | 38 +++
 rtl/video_axis_counter.sv | 57 +++++
 rtl/video_timing_ctrl.sv | 143 ++++++++++++++
 tb/tb_video_timing_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared states, default 1600x900 timing and axis timing helper
package video_timing_pkg;

  typedef enum logic [1:0] {
    VTG_IDLE  = 2'd0,
    VTG_RUN   = 2'd1,
    VTG_DRAIN = 2'd2
  } vtg_state_t;

  localparam int VTG_CNT_W     = 11;
  localparam int VTG_MAX_TOTAL = 2048;

  localparam int VTG_HRES = 1600;
  localparam int VTG_VRES = 900;
  localparam int VTG_H_FP = 24;
  localparam int VTG_H_SW = 80;
  localparam int VTG_H_BP = 96;
  localparam int VTG_V_FP = 1;
  localparam int VTG_V_SW = 3;
  localparam int VTG_V_BP = 96;
  localparam bit VTG_SYNC_POL = 1'b1;

  typedef struct packed {
    int total;
    int sync_start;
    int sync_end;
  } vtg_axis_t;

  // Total length and sync window [sync_start, sync_end) of one raster axis.
  function automatic vtg_axis_t vtg_axis_timing(input int act, input int fp, input int sw, input int bp);
    vtg_axis_t t;
    t.total      = act + fp + sw + bp;
    t.sync_start = act + fp;
    t.sync_end   = act + fp + sw;
    return t;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// rtl/video_axis_counter.sv - wrap counter with clear, wrap pulse and registered window decode
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int CNT_W      = VTG_CNT_W,
  parameter int MAX        = 1800,
  parameter int ACT_END    = 1600,
  parameter int SYNC_START = 1624,
  parameter int SYNC_END   = 1704
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(MAX - 1);
  localparam logic [CNT_W:0]   ACT_L  = (CNT_W + 1)'(ACT_END);
  localparam logic [CNT_W:0]   SS_L   = (CNT_W + 1)'(SYNC_START);
  localparam logic [CNT_W:0]   SE_L   = (CNT_W + 1)'(SYNC_END);

  logic [CNT_W:0] next_ext;

  assign wrap     = en && (cnt == LAST);
  assign next_ext = {1'b0, cnt_next};

  // Next count: clear dominates, then wrap, then increment.
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (wrap) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Count register plus window flags decoded from the next count so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      active <= 1'b0;
      sync   <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      active <= !clr && (next_ext < ACT_L);
      sync   <= !clr && (next_ext >= SS_L) && (next_ext < SE_L);
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - start/stop raster timing sequencer; optional frame_cnt under VTG_FRAME_CNT_EN
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int HRES     = VTG_HRES,
  parameter int VRES     = VTG_VRES,
  parameter int H_FP     = VTG_H_FP,
  parameter int H_SW     = VTG_H_SW,
  parameter int H_BP     = VTG_H_BP,
  parameter int V_FP     = VTG_V_FP,
  parameter int V_SW     = VTG_V_SW,
  parameter int V_BP     = VTG_V_BP,
  parameter bit SYNC_POL = VTG_SYNC_POL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic [VTG_CNT_W-1:0] h_cnt,
  output logic [VTG_CNT_W-1:0] v_cnt,
  output logic                 dv,
  output logic                 hs,
  output logic                 vs,
  output logic                 frame_start,
  output logic                 line_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam vtg_axis_t H_T = vtg_axis_timing(HRES, H_FP, H_SW, H_BP);
  localparam vtg_axis_t V_T = vtg_axis_timing(VRES, V_FP, V_SW, V_BP);
  localparam logic [VTG_CNT_W:0] VRES_L = (VTG_CNT_W + 1)'(VRES);

  if (H_T.total > VTG_MAX_TOTAL) begin : g_htotal_too_big
    $error("video_timing_ctrl: HTOTAL exceeds 2048");
  end
  if (V_T.total > VTG_MAX_TOTAL) begin : g_vtotal_too_big
    $error("video_timing_ctrl: VTOTAL exceeds 2048");
  end

  vtg_state_t state, next_state;
  logic run_now, run_next, last_pix;
  logic h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic [VTG_CNT_W-1:0] h_next, v_next;

  assign run_now  = (state != VTG_IDLE);
  assign run_next = (next_state != VTG_IDLE);
  assign last_pix = h_wrap && v_wrap;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= VTG_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: stop wins in RUN, start cancels a pending drain, drain ends on the last pixel.
  always_comb begin
    next_state = state;
    case (state)
      VTG_IDLE:  if (start && !stop) next_state = VTG_RUN;
      VTG_RUN:   if (stop) next_state = VTG_DRAIN;
      VTG_DRAIN: begin
        if (start) begin
          next_state = VTG_RUN;
        end else if (last_pix) begin
          next_state = VTG_IDLE;
        end
      end
      default:   next_state = VTG_IDLE;
    endcase
  end

  video_axis_counter #(
    .CNT_W      (VTG_CNT_W),
    .MAX        (H_T.total),
    .ACT_END    (HRES),
    .SYNC_START (H_T.sync_start),
    .SYNC_END   (H_T.sync_end)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (run_now),
    .clr      (!run_next),
    .cnt      (h_cnt),
    .cnt_next (h_next),
    .wrap     (h_wrap),
    .active   (h_act),
    .sync     (h_sync)
  );

  video_axis_counter #(
    .CNT_W      (VTG_CNT_W),
    .MAX        (V_T.total),
    .ACT_END    (VRES),
    .SYNC_START (V_T.sync_start),
    .SYNC_END   (V_T.sync_end)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (run_now && h_wrap),
    .clr      (!run_next),
    .cnt      (v_cnt),
    .cnt_next (v_next),
    .wrap     (v_wrap),
    .active   (v_act),
    .sync     (v_sync)
  );

  assign dv = h_act && v_act;
  assign hs = SYNC_POL ? h_sync : !h_sync;
  assign vs = SYNC_POL ? v_sync : !v_sync;

  // Busy and start pulses registered from the next state and next counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      busy        <= run_next;
      frame_start <= run_next && (h_next == '0) && (v_next == '0);
      line_start  <= run_next && (h_next == '0) && ({1'b0, v_next} < VRES_L);
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Completed-frame counter, bumped after each final pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= 16'd0;
    end else if (run_now && last_pix) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - directed self-checking bench; frame_cnt checks under VTG_FRAME_CNT_EN
module tb_video_timing_ctrl;

  localparam int HT  = 12;
  localparam int FRM = 84;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;

  logic        busy, dv, hs, vs, frame_start, line_start;
  logic [10:0] h_cnt, v_cnt;
  logic        n_busy, n_dv, n_hs, n_vs, n_frame_start, n_line_start;
  logic [10:0] n_h_cnt, n_v_cnt;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt, n_frame_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int dv_total;

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .HRES(8), .VRES(4), .H_FP(1), .H_SW(2), .H_BP(1),
    .V_FP(1), .V_SW(1), .V_BP(1), .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .dv(dv), .hs(hs), .vs(vs),
    .frame_start(frame_start), .line_start(line_start)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  video_timing_ctrl #(
    .HRES(8), .VRES(4), .H_FP(1), .H_SW(2), .H_BP(1),
    .V_FP(1), .V_SW(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_neg (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(n_busy),
    .h_cnt(n_h_cnt), .v_cnt(n_v_cnt), .dv(n_dv), .hs(n_hs), .vs(n_vs),
    .frame_start(n_frame_start), .line_start(n_line_start)
`ifdef VTG_FRAME_CNT_EN
    , .frame_cnt(n_frame_cnt)
`endif
  );

  wire [27:0] obs   = {busy, h_cnt, v_cnt, dv, hs, vs, frame_start, line_start};
  wire [27:0] n_obs = {n_busy, n_h_cnt, n_v_cnt, n_dv, n_hs, n_vs, n_frame_start, n_line_start};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs for frame-relative cycle k of an 8x4 frame in a 12x7 raster.
  function automatic logic [27:0] exp_vec(input int k, input bit pol);
    int h, v;
    logic [10:0] hh, vv;
    bit x_dv, x_hs, x_vs, x_fs, x_ls;
    h = k % HT;
    v = k / HT;
    hh = 11'(h);
    vv = 11'(v);
    x_dv = (h < 8) && (v < 4);
    x_hs = (h == 9) || (h == 10);
    x_vs = (v == 5);
    x_fs = (k == 0);
    x_ls = (h == 0) && (v < 4);
    return {1'b1, hh, vv, x_dv, pol ? x_hs : !x_hs, pol ? x_vs : !x_vs, x_fs, x_ls};
  endfunction

  function automatic logic [27:0] idle_vec(input bit pol);
    return {1'b0, 22'd0, 1'b0, !pol, !pol, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic [27:0] e, input logic [27:0] ne);
    check_val(tag, {4'd0, obs}, {4'd0, e});
    check_val({tag, " inv"}, {4'd0, n_obs}, {4'd0, ne});
  endtask

  initial begin
    // Reset held, then released and left idle.
    step();
    check_cycle("reset", idle_vec(1'b1), idle_vec(1'b0));
`ifdef VTG_FRAME_CNT_EN
    check_val("reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
    step();
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      check_cycle($sformatf("idle %0d", i), idle_vec(1'b1), idle_vec(1'b0));
    end

    // A: start, stop at (3,2); frame drains to (11,6) then IDLE.
    dv_total = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < FRM; k++) begin
      check_cycle($sformatf("A k=%0d", k), exp_vec(k, 1'b1), exp_vec(k, 1'b0));
      dv_total += int'(dv);
      stop = (k == 27);
      step();
    end
    stop = 1'b0;
    check_val("A dv count", dv_total, 32);
    check_cycle("A idle", idle_vec(1'b1), idle_vec(1'b0));
`ifdef VTG_FRAME_CNT_EN
    check_val("A frame_cnt", {16'd0, frame_cnt}, 32'd1);
`endif
    step();
    check_cycle("A idle+1", idle_vec(1'b1), idle_vec(1'b0));

    // B: drain cancelled mid-frame, cancelled on last pixel, then start+stop in RUN drains.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3 * FRM; k++) begin
      check_cycle($sformatf("B k=%0d", k), exp_vec(k % FRM, 1'b1), exp_vec(k % FRM, 1'b0));
      start = (k == 40) || (k == 167) || (k == 171);
      stop  = (k == 20) || (k == 111) || (k == 171);
      step();
    end
    start = 1'b0;
    stop = 1'b0;
    check_cycle("B idle", idle_vec(1'b1), idle_vec(1'b0));
`ifdef VTG_FRAME_CNT_EN
    check_val("B frame_cnt", {16'd0, frame_cnt}, 32'd4);
`endif

    // start together with stop in IDLE is ignored.
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check_cycle("idle start+stop", idle_vec(1'b1), idle_vec(1'b0));
    step();
    check_cycle("idle start+stop+1", idle_vec(1'b1), idle_vec(1'b0));

    // C: asynchronous reset at (5,1).
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      check_cycle($sformatf("C k=%0d", k), exp_vec(k, 1'b1), exp_vec(k, 1'b0));
      if (k < 17) step();
    end
    rst = 1'b0;
    #1;
    check_cycle("C async reset", idle_vec(1'b1), idle_vec(1'b0));
`ifdef VTG_FRAME_CNT_EN
    check_val("C frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
    step();
    rst = 1'b1;
    step();
    step();
    check_cycle("C after release", idle_vec(1'b1), idle_vec(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
